// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: active-low glyph
// patterns (gfedcba), the blank BCD code and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } seg7_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse decoder: active-low 7-segment pattern to BCD, with
// blank and illegal-glyph flags.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       blank,
  output logic       err
);

  // Map each legal glyph to its digit; anything else is an error.
  always_comb begin
    bcd   = BCD_BLANK;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG7_0:     bcd = 4'd0;
      SEG7_1:     bcd = 4'd1;
      SEG7_2:     bcd = 4'd2;
      SEG7_3:     bcd = 4'd3;
      SEG7_4:     bcd = 4'd4;
      SEG7_5:     bcd = 4'd5;
      SEG7_6:     bcd = 4'd6;
      SEG7_7:     bcd = 4'd7;
      SEG7_8:     bcd = 4'd8;
      SEG7_9:     bcd = 4'd9;
      SEG7_BLANK: blank = 1'b1;
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed active-low common-anode 7-segment bus and rebuilds
// the per-digit BCD value once the sampled pattern has been stable.
// Optional per-digit refresh timeout: define SEG7_SCAN_TIMEOUT_EN.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic [N_DIGITS-1:0]   digit_blank,
  output logic                  capture_strobe,
  output logic [IDX_W-1:0]      capture_idx,
  output logic                  decode_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (N_DIGITS < 1 || N_DIGITS > 8 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("seg7_scan_capture: parameter out of range");
  end

  function automatic logic onehot_low(input logic [N_DIGITS-1:0] an);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      if (!an[i]) n++;
    return n == 1;
  endfunction

  function automatic logic [IDX_W-1:0] low_index(input logic [N_DIGITS-1:0] an);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      if (!an[i]) r = IDX_W'(i);
    return r;
  endfunction

  logic [N_DIGITS-1:0] s_an;
  logic [6:0]          s_seg;
  logic [CNT_W-1:0]    cnt;
  seg7_state_t         state;

  logic             changed;
  logic             in_onehot;
  logic             capture;
  logic [IDX_W-1:0] s_idx;
  logic [3:0]       dec_bcd;
  logic             dec_blank;
  logic             dec_err;

  // State decisions look at the value about to enter S so that the FSM and
  // the stability counter move on the same edge as S itself.
  assign changed   = (an_in != s_an) || (seg_in != s_seg);
  assign in_onehot = onehot_low(an_in);
  assign s_idx     = low_index(s_an);
  assign capture   = (state == SETTLE) && !changed && in_onehot && (cnt == CNT_LAST);

  seg7_glyph_decode u_decode (
    .seg   (s_seg),
    .bcd   (dec_bcd),
    .blank (dec_blank),
    .err   (dec_err)
  );

  // Input sample register S.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an  <= '1;
      s_seg <= SEG7_BLANK;
    end else begin
      s_an  <= an_in;
      s_seg <= seg_in;
    end
  end

  // Stability counter: restarts on any change of S, saturates at STABLE_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (changed) cnt <= '0;
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt [N_DIGITS];
`endif

  // Capture FSM with registered per-digit results; a capture in the same
  // cycle as a timeout overrides it because it is assigned last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bcd_out        <= {N_DIGITS{BCD_BLANK}};
      digit_valid    <= '0;
      digit_blank    <= '0;
      capture_strobe <= 1'b0;
      capture_idx    <= '0;
      decode_err     <= 1'b0;
`ifdef SEG7_SCAN_TIMEOUT_EN
      for (int unsigned i = 0; i < N_DIGITS; i++) tcnt[i] <= '0;
`endif
    end else begin
      capture_strobe <= 1'b0;
      decode_err     <= 1'b0;

      if (!in_onehot) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= SETTLE;
          SETTLE:  if (capture) state <= HELD;
          HELD:    if (changed) state <= SETTLE;
          default: state <= IDLE;
        endcase
      end

`ifdef SEG7_SCAN_TIMEOUT_EN
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
        if (tcnt[i] != TCNT_MAX) tcnt[i] <= tcnt[i] + TCNT_W'(1);
        if (tcnt[i] == TCNT_LAST) begin
          digit_valid[i] <= 1'b0;
          digit_blank[i] <= 1'b0;
        end
      end
`endif

      if (capture) begin
        capture_strobe <= 1'b1;
        capture_idx    <= s_idx;
`ifdef SEG7_SCAN_TIMEOUT_EN
        tcnt[s_idx]    <= '0;
`endif
        if (dec_err) begin
          decode_err         <= 1'b1;
          digit_valid[s_idx] <= 1'b0;
          digit_blank[s_idx] <= 1'b0;
        end else begin
          bcd_out[4*s_idx +: 4] <= dec_bcd;
          digit_valid[s_idx]    <= 1'b1;
          digit_blank[s_idx]    <= dec_blank;
        end
      end
    end
  end

endmodule
